// File: rtl/router_fsm_pkg.sv
// Shared router definitions: controller state encoding, address constants and
// small per-port decode helpers.
package router_fsm_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned PORTS  = 3;
  localparam int unsigned CNT_W  = 8;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [3:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    DROP_PACKET
  } state_e;

  // Select one port's flag by address; the invalid address reads as 0.
  function automatic logic port_bit(input logic [PORTS-1:0] v,
                                    input logic [ADDR_W-1:0] a);
    case (a)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  // One-hot port select for an address; the invalid address selects nothing.
  function automatic logic [PORTS-1:0] port_onehot(input logic [ADDR_W-1:0] a);
    case (a)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Router packet controller: steers one packet at a time from the source into
// the addressed output FIFO, stalling on full FIFOs and dropping bad addresses.
module router_fsm
  import router_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       packet_valid,
  input  logic [1:0] datain,
  input  logic       fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy,
  output logic [2:0] fifo_sel,
  output logic [7:0] drop_cnt
);

  state_e              state, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    drop_cnt_d;
  logic                detect_add_d, lfd_state_d, ld_state_d, laf_state_d;
  logic                full_state_d, rst_int_reg_d, write_enb_d, busy_d;
  logic [PORTS-1:0]    fifo_sel_d;

  // State, latched address and all outputs; outputs are decoded from the
  // next state so they line up with the state register cycle for cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= DECODE_ADDRESS;
      addr_q        <= '0;
      drop_cnt      <= '0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
      fifo_sel      <= '0;
    end else begin
      state         <= state_d;
      addr_q        <= addr_d;
      drop_cnt      <= drop_cnt_d;
      detect_add    <= detect_add_d;
      lfd_state     <= lfd_state_d;
      ld_state      <= ld_state_d;
      laf_state     <= laf_state_d;
      full_state    <= full_state_d;
      rst_int_reg   <= rst_int_reg_d;
      write_enb_reg <= write_enb_d;
      busy          <= busy_d;
      fifo_sel      <= fifo_sel_d;
    end
  end

  // Next-state, address latch, drop counter and output decode.
  always_comb begin
    state_d       = state;
    addr_d        = addr_q;
    drop_cnt_d    = drop_cnt;
    detect_add_d  = 1'b0;
    lfd_state_d   = 1'b0;
    ld_state_d    = 1'b0;
    laf_state_d   = 1'b0;
    full_state_d  = 1'b0;
    rst_int_reg_d = 1'b0;
    write_enb_d   = 1'b0;
    busy_d        = 1'b1;
    fifo_sel_d    = '0;

    case (state)
      DECODE_ADDRESS: begin
        if (packet_valid) begin
          addr_d = datain;
          if (datain == ADDR_INVALID)         state_d = DROP_PACKET;
          else if (port_bit(fifo_empty, datain)) state_d = LOAD_FIRST_DATA;
          else                                 state_d = WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY:
        if (port_bit(fifo_empty, addr_q)) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)          state_d = FIFO_FULL_STATE;
        else if (!packet_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE:
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)           state_d = DECODE_ADDRESS;
        else if (low_packet_valid) state_d = LOAD_PARITY;
        else                       state_d = LOAD_DATA;
      end
      LOAD_PARITY:
        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      DROP_PACKET:
        if (!packet_valid) state_d = DECODE_ADDRESS;
      default:
        state_d = DECODE_ADDRESS;
    endcase

    // A soft reset of the port being written abandons the packet.
    if (state != DECODE_ADDRESS && state != DROP_PACKET &&
        port_bit(soft_reset, addr_q))
      state_d = DECODE_ADDRESS;

    if (state != DROP_PACKET && state_d == DROP_PACKET &&
        drop_cnt != {CNT_W{1'b1}})
      drop_cnt_d = drop_cnt + CNT_W'(1);

    detect_add_d  = (state_d == DECODE_ADDRESS);
    lfd_state_d   = (state_d == LOAD_FIRST_DATA);
    ld_state_d    = (state_d == LOAD_DATA);
    laf_state_d   = (state_d == LOAD_AFTER_FULL);
    full_state_d  = (state_d == FIFO_FULL_STATE);
    rst_int_reg_d = (state_d == CHECK_PARITY_ERROR);
    write_enb_d   = (state_d == LOAD_FIRST_DATA) || (state_d == LOAD_DATA) ||
                    (state_d == LOAD_AFTER_FULL) || (state_d == LOAD_PARITY);
    busy_d        = !((state_d == DECODE_ADDRESS) || (state_d == LOAD_DATA) ||
                      (state_d == DROP_PACKET));
    fifo_sel_d    = write_enb_d ? port_onehot(addr_d) : '0;
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: steps the controller one clock at a time and
// compares the strobe vector, fifo_sel and drop_cnt against hand-derived values.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       packet_valid;
  logic [1:0] datain;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_packet_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic       write_enb_reg, busy;
  logic [2:0] fifo_sel;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Bench-side state labels
  localparam int S_DEC = 0, S_WAIT = 1, S_LFD = 2, S_LD = 3, S_FULL = 4,
                 S_LAF = 5, S_LP = 6, S_CHK = 7, S_DROP = 8;

  router_fsm dut (
    .clk(clk), .rst(rst), .packet_valid(packet_valid), .datain(datain),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .fifo_sel(fifo_sel),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy} expected per state
  function automatic logic [7:0] exp_vec(input int st);
    case (st)
      S_DEC:   return 8'b1000_0000;
      S_WAIT:  return 8'b0000_0001;
      S_LFD:   return 8'b0100_0011;
      S_LD:    return 8'b0010_0010;
      S_FULL:  return 8'b0000_1001;
      S_LAF:   return 8'b0001_0011;
      S_LP:    return 8'b0000_0011;
      S_CHK:   return 8'b0000_0101;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input int st, input logic [2:0] sel);
    check({tag, ".strobes"},
          32'({detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy}),
          32'(exp_vec(st)));
    check({tag, ".fifo_sel"}, 32'(fifo_sel), 32'(sel));
  endtask

  initial begin
    rst = 1'b1; packet_valid = 1'b0; datain = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0;
    low_packet_valid = 1'b0;
    step; step;
    rst = 1'b0;
    expect_state("reset", S_DEC, 3'b000);
    check("reset.drop_cnt", 32'(drop_cnt), 32'd0);

    // Normal packet to port 1
    packet_valid = 1'b1; datain = 2'd1;
    step; expect_state("p1.lfd", S_LFD, 3'b010);
    for (int i = 0; i < 3; i++) begin
      step; expect_state($sformatf("p1.ld%0d", i), S_LD, 3'b010);
    end
    packet_valid = 1'b0;
    step; expect_state("p1.lp", S_LP, 3'b010);
    step; expect_state("p1.chk", S_CHK, 3'b000);
    step; expect_state("p1.dec", S_DEC, 3'b000);

    // Port 0 not empty for 4 cycles
    packet_valid = 1'b1; datain = 2'd0; fifo_empty = 3'b110;
    for (int i = 0; i < 4; i++) begin
      step; expect_state($sformatf("p0.wait%0d", i), S_WAIT, 3'b000);
    end
    fifo_empty = 3'b111;
    step; expect_state("p0.lfd", S_LFD, 3'b001);
    step; expect_state("p0.ld", S_LD, 3'b001);

    // FIFO full for 3 cycles mid-payload
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step; expect_state($sformatf("p0.full%0d", i), S_FULL, 3'b000);
    end
    fifo_full = 1'b0;
    step; expect_state("p0.laf", S_LAF, 3'b001);
    step; expect_state("p0.ld2", S_LD, 3'b001);

    // Full again, then low_packet_valid from LOAD_AFTER_FULL
    fifo_full = 1'b1;
    step; expect_state("p0.full_b", S_FULL, 3'b000);
    fifo_full = 1'b0; packet_valid = 1'b0; low_packet_valid = 1'b1;
    step; expect_state("p0.laf_b", S_LAF, 3'b001);
    step; expect_state("p0.lp", S_LP, 3'b001);
    low_packet_valid = 1'b0; fifo_full = 1'b1;
    step; expect_state("p0.chk", S_CHK, 3'b000);
    step; expect_state("p0.chk_full", S_FULL, 3'b000);
    fifo_full = 1'b0; parity_done = 1'b1;
    step; expect_state("p0.laf_c", S_LAF, 3'b001);
    step; expect_state("p0.laf_done", S_DEC, 3'b000);
    parity_done = 1'b0;

    // Invalid address: dropped, never writes
    packet_valid = 1'b1; datain = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step; expect_state($sformatf("drop.hold%0d", i), S_DROP, 3'b000);
      check($sformatf("drop.cnt%0d", i), 32'(drop_cnt), 32'd1);
    end
    packet_valid = 1'b0;
    step; expect_state("drop.dec", S_DEC, 3'b000);

    // 255 more dropped packets, counter saturates
    for (int n = 2; n <= 256; n++) begin
      packet_valid = 1'b1; step;
      packet_valid = 1'b0; step;
      if (n == 254 || n == 255)
        check($sformatf("drop.cnt_n%0d", n), 32'(drop_cnt), 32'(n));
    end
    check("drop.cnt_sat", 32'(drop_cnt), 32'd255);

    // Soft reset on port 2 during LOAD_DATA; port 0 soft reset ignored
    packet_valid = 1'b1; datain = 2'd2;
    step; expect_state("sr.lfd", S_LFD, 3'b100);
    step; expect_state("sr.ld", S_LD, 3'b100);
    soft_reset = 3'b001;
    step; expect_state("sr.other", S_LD, 3'b100);
    soft_reset = 3'b100; packet_valid = 1'b0;
    step; expect_state("sr.own", S_DEC, 3'b000);
    soft_reset = 3'b000;

    // Hard reset while stalled on a full FIFO
    packet_valid = 1'b1; datain = 2'd1;
    step; expect_state("rst.lfd", S_LFD, 3'b010);
    step; expect_state("rst.ld", S_LD, 3'b010);
    fifo_full = 1'b1;
    step; expect_state("rst.full", S_FULL, 3'b000);
    rst = 1'b1; soft_reset = 3'b010;
    step; expect_state("rst.dec", S_DEC, 3'b000);
    check("rst.drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0; soft_reset = 3'b000; fifo_full = 1'b0; packet_valid = 1'b0;
    step; expect_state("rst.idle", S_DEC, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port packet_valid  input  1  source asserts for header+payload bytes; deasserts on parity byte.
REQ-004 SHALL have port datain  input  2  address field of header byte (datain[1:0]); 2'b11 is invalid.
REQ-005 SHALL have port fifo_full  input  1  full flag of the currently selected output FIFO.
REQ-006 SHALL have port fifo_empty  input  3  per-port FIFO empty flags, bit n = port n.
REQ-007 SHALL have port soft_reset  input  3  per-port soft reset pulses from the synchronizer.
REQ-008 SHALL have port parity_done  input  1  from the register block; parity byte captured.
REQ-009 SHALL have port low_packet_valid  input  1  from the register block; packet_valid has fallen.
REQ-010 SHALL have outputs detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  output  1 each  state strobes driving the register block.
REQ-011 SHALL have port write_enb_reg  output  1  write enable toward the FIFOs.
REQ-012 SHALL have port busy  output  1  stalls the source.
REQ-013 SHALL have port fifo_sel  output  3  one-hot destination port, from the latched address.
REQ-014 SHALL have port drop_cnt  output  8  count of packets discarded for invalid address.

Function
REQ-015 SHALL implement states DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, DROP_PACKET.
REQ-016 SHALL in DECODE_ADDRESS with packet_valid: latch datain into addr_q; datain=3 -> DROP_PACKET; else fifo_empty[datain]=1 -> LOAD_FIRST_DATA, else -> WAIT_TILL_EMPTY; no packet_valid -> hold.
REQ-017 SHALL leave WAIT_TILL_EMPTY for LOAD_FIRST_DATA the cycle after fifo_empty[addr_q]=1.
REQ-018 SHALL go LOAD_FIRST_DATA -> LOAD_DATA unconditionally (one cycle).
REQ-019 SHALL in LOAD_DATA: fifo_full -> FIFO_FULL_STATE (priority); else !packet_valid -> LOAD_PARITY; else hold.
REQ-020 SHALL in FIFO_FULL_STATE hold while fifo_full, then -> LOAD_AFTER_FULL.
REQ-021 SHALL in LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_packet_valid -> LOAD_PARITY; else -> LOAD_DATA.
REQ-022 SHALL go LOAD_PARITY -> CHECK_PARITY_ERROR; CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
REQ-023 SHALL in DROP_PACKET hold while packet_valid, then -> DECODE_ADDRESS; increment drop_cnt once on entry, saturating at 255.
REQ-024 SHALL, in any state other than DECODE_ADDRESS/DROP_PACKET, go to DECODE_ADDRESS when soft_reset[addr_q]=1, overriding all other transitions; soft_reset of other ports ignored.
REQ-025 SHALL decode outputs as Moore functions of state: detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, laf_state=LOAD_AFTER_FULL, full_state=FIFO_FULL_STATE, rst_int_reg=CHECK_PARITY_ERROR.
REQ-026 SHALL assert write_enb_reg in LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY.
REQ-027 SHALL deassert busy only in DECODE_ADDRESS, LOAD_DATA, DROP_PACKET.
REQ-028 SHALL drive fifo_sel = one-hot(addr_q) while write_enb_reg=1, else 3'b000.

Reset
REQ-029 SHALL on rst=1 set state DECODE_ADDRESS, addr_q=0, drop_cnt=0; rst overrides soft_reset and all transitions, including mid-packet.
REQ-030 SHALL therefore present after reset: detect_add=1, all other strobes 0, write_enb_reg=0, busy=0, fifo_sel=0.

Structure
REQ-031 SHALL place the state enumeration and constant ADDR_INVALID=2'b11 in the shared router package.
REQ-032 SHALL be a single module; no sub-module.

Verification
REQ-033 SHALL cover: header addr=1, fifo_empty=3'b111, 3 payload bytes, parity -> states DECODE,LFD,LD x3,LOAD_PARITY,CHECK,DECODE; fifo_sel=3'b010 during writes.
REQ-034 SHALL cover: header addr=0, fifo_empty[0]=0 for 4 cycles -> WAIT_TILL_EMPTY, busy=1 for 4 cycles, then LFD.
REQ-035 SHALL cover: fifo_full=1 for 3 cycles mid-payload -> FIFO_FULL_STATE x3, full_state=1, busy=1, then LOAD_AFTER_FULL -> LOAD_DATA.
REQ-036 SHALL cover: header addr=3 held 5 cycles -> DROP_PACKET, write_enb_reg=0 throughout, drop_cnt 0->1; 256 such packets -> drop_cnt=255.
REQ-037 SHALL cover: soft_reset=3'b100 during LOAD_DATA to port 2 -> DECODE next cycle; soft_reset=3'b001 in same case -> no effect.
REQ-038 SHALL cover: rst=1 in FIFO_FULL_STATE -> DECODE_ADDRESS next cycle, drop_cnt=0.
